risc_16bit_controller: RTL and testbench
========================================

RISC_16BIT_CONTROLLER -- requirements
Module: risc_16bit_controller

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning data and instruction width.
REQ-002 The block SHALL have parameter PC_W, default 8, meaning program counter and memory address width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low: clk input 1 (rising-edge clock) and rst_n input 1 (synchronous active-low reset).
REQ-004 Instruction memory ports SHALL be: I_addr output PC_W (fetch address); I_rd output 1 (fetch strobe); I_data input W (instruction, valid one cycle after I_rd).
REQ-005 Data memory ports SHALL be: D_addr output PC_W; D_rd output 1; D_wr output 1.
REQ-006 Datapath ports SHALL be:
- RF_W_data output W-8 (immediate)
- RF_s1, RF_s0 outputs 1 each (write-mux select: 00=ALU, 01=D_data, 10=sign-extended immediate)
- RF_W_addr output 4; W_wr output 1
- RF_Rp_addr output 4; Rp_rd output 1
- RF_Rq_addr output 4; Rq_rd output 1
- alu_s output 3
- RF_Rp_zero input 1 (Rp data equals zero)
REQ-007 The block SHALL have halted output 1, high while in HALT.

Function
REQ-008 Registers: PC (PC_W bits) and IR (W bits); all other outputs SHALL be Moore-decoded from state and IR.
REQ-009 Any strobe, select or address not named for the current state SHALL be 0.
REQ-010 IR fields SHALL be: op=IR[15:12], ra=IR[11:8], rb=IR[7:4], rc=IR[3:0], imm8=IR[7:0].
REQ-011 States SHALL be INIT, FETCH, DECODE, LD1, LD2, ST1, ST2, ALU1, ALU2, LI, JZ1, JZ2, HALT.
REQ-012 INIT: all strobes 0; next state FETCH.
REQ-013 FETCH: I_addr=PC, I_rd=1; next state DECODE.
REQ-014 DECODE: IR<=I_data; PC<=PC+1, wrapping 255->0. Next state by op:
- 0000 -> LD1
- 0001 -> ST1
- 0011 -> LI
- 0101 -> JZ1
- ALU ops (0010, 0100, 0110-1011) -> ALU1
- 1111 -> HALT
- any other op -> FETCH (NOP)
REQ-015 Decode of IR SHALL use the I_data value captured in DECODE; IR is stable through the execute states.
REQ-016 Load (op 0000, RF[ra]<=D[imm8]):
- LD1: D_addr=imm8, D_rd=1
- LD2: RF_s1:s0=01, RF_W_addr=ra, W_wr=1; next state FETCH
REQ-017 Store (op 0001, D[imm8]<=RF[ra]):
- ST1: RF_Rp_addr=ra, Rp_rd=1
- ST2: D_addr=imm8, D_wr=1; next state FETCH
REQ-018 LI (op 0011): RF_s1:s0=10, RF_W_data=imm8, RF_W_addr=ra, W_wr=1; next state FETCH.
REQ-019 ALU ops (RF[ra]<=RF[rb] op RF[rc]):
- ALU1: RF_Rp_addr=rb, Rp_rd=1, RF_Rq_addr=rc, Rq_rd=1
- ALU2: alu_s per op, RF_s1:s0=00, RF_W_addr=ra, W_wr=1; next state FETCH
REQ-020 ALU op to alu_s mapping SHALL be: 0010 ADD=000, 0100 SUB=001, 0110 AND=010, 0111 OR=011, 1000 XOR=100, 1001 NOT=101, 1010 SLA=110, 1011 SRA=111.
REQ-021 JMPZ (op 0101):
- JZ1: RF_Rp_addr=ra, Rp_rd=1
- JZ2: if RF_Rp_zero=1, PC<=PC+sext(imm8) modulo 2^PC_W, where PC is the already-incremented value; otherwise PC unchanged
- next state FETCH
REQ-022 RF_Rp_zero SHALL be sampled only in JZ2.
REQ-023 HALT: halted=1, all strobes 0; remains in HALT until reset.
REQ-024 Cycle counts including FETCH and DECODE SHALL be: LI=3, load/store/ALU/JMPZ=4, NOP=2.

Reset
REQ-025 rst_n=0 at any rising edge, including mid-instruction or in HALT, SHALL set state=INIT, PC=0, IR=0, halted=0, and all strobes 0.
REQ-026 No write strobe (W_wr, D_wr) SHALL assert in the cycle following reset assertion.

Verification
REQ-027 Reset, then I_data[0]=0x3A85 (LI): cycle 3 shows RF_s1:s0=10, RF_W_data=0x85, RF_W_addr=0xA, W_wr=1; then FETCH with I_addr=1.
REQ-028 ADD 0x2123: ALU1 Rp_addr=2, Rq_addr=3, both rd=1; ALU2 alu_s=000, W_addr=1, W_wr=1, s1:s0=00; SUB 0x4123 gives alu_s=001.
REQ-029 Load 0x0510 then store 0x1620: LD1 D_addr=0x10, D_rd=1; LD2 W_addr=5, s1:s0=01; ST1 Rp_addr=6; ST2 D_addr=0x20, D_wr=1.
REQ-030 JMPZ 0x52FE at PC=4: with RF_Rp_zero=1, the next I_addr=3; with RF_Rp_zero=0, the next I_addr=5. JMPZ 0x5205 at PC=255 gives I_addr=5 (wrap-around).
REQ-031 HALT 0xF000: halted=1 and no strobes for 10 cycles; rst_n=0 returns to INIT with PC=0.
REQ-032 rst_n=0 during ALU1: the next cycle has W_wr=0, state INIT, PC=0; undefined op 0xC000 costs 2 cycles with no strobes.

Source files
------------

// File: rtl/risc_16bit_controller.sv
// rtl/risc_16bit_controller.sv - multi-cycle control unit for a 16-bit RISC datapath
//
// Purpose: fetches instructions, decodes them and sequences the register
// file, ALU and data memory through the execute states. PC and IR are the only
// data registers. Every other output is decoded from the current state and IR.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   I_addr, I_rd         instruction fetch address and strobe
//   I_data               instruction word, valid the cycle after I_rd
//   D_addr, D_rd, D_wr   data memory address and read/write strobes
//   RF_W_data            immediate for the register-file write mux
//   RF_s1, RF_s0         write-mux select (00 ALU, 01 D_data, 10 immediate)
//   RF_W_addr, W_wr      register-file write port
//   RF_Rp_addr, Rp_rd    register-file read port P
//   RF_Rq_addr, Rq_rd    register-file read port Q
//   alu_s                ALU function select
//   RF_Rp_zero           read port P data equals zero
//   halted               high while in HALT
module risc_16bit_controller #(
    parameter int W    = 16,
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] I_addr,
    output logic            I_rd,
    input  logic [W-1:0]    I_data,
    output logic [PC_W-1:0] D_addr,
    output logic            D_rd,
    output logic            D_wr,
    output logic [W-9:0]    RF_W_data,
    output logic            RF_s1,
    output logic            RF_s0,
    output logic [3:0]      RF_W_addr,
    output logic            W_wr,
    output logic [3:0]      RF_Rp_addr,
    output logic            Rp_rd,
    output logic [3:0]      RF_Rq_addr,
    output logic            Rq_rd,
    output logic [2:0]      alu_s,
    input  logic            RF_Rp_zero,
    output logic            halted
);

    typedef enum logic [3:0] {
        S_INIT, S_FETCH, S_DECODE, S_LD1, S_LD2, S_ST1, S_ST2,
        S_ALU1, S_ALU2, S_LI, S_JZ1, S_JZ2, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [W-1:0]    ir_q, ir_d;

    logic [3:0]      op, ra, rb, rc;
    logic [PC_W-1:0] imm_addr;
    logic [PC_W-1:0] imm_sext;

    assign op       = ir_q[15:12];
    assign ra       = ir_q[11:8];
    assign rb       = ir_q[7:4];
    assign rc       = ir_q[3:0];
    assign imm_addr = PC_W'(ir_q[7:0]);
    // Jump offset is a signed byte; the cast to PC_W sign-extends it.
    assign imm_sext = PC_W'($signed(ir_q[7:0]));

    function automatic logic [2:0] alu_sel(input logic [3:0] o);
        case (o)
            4'b0100: alu_sel = 3'b001;
            4'b0110: alu_sel = 3'b010;
            4'b0111: alu_sel = 3'b011;
            4'b1000: alu_sel = 3'b100;
            4'b1001: alu_sel = 3'b101;
            4'b1010: alu_sel = 3'b110;
            4'b1011: alu_sel = 3'b111;
            default: alu_sel = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        I_addr     = '0;
        I_rd       = 1'b0;
        D_addr     = '0;
        D_rd       = 1'b0;
        D_wr       = 1'b0;
        RF_W_data  = '0;
        RF_s1      = 1'b0;
        RF_s0      = 1'b0;
        RF_W_addr  = '0;
        W_wr       = 1'b0;
        RF_Rp_addr = '0;
        Rp_rd      = 1'b0;
        RF_Rq_addr = '0;
        Rq_rd      = 1'b0;
        alu_s      = '0;
        halted     = 1'b0;
        case (state_q)
            S_INIT:  state_d = S_FETCH;
            S_FETCH: begin
                I_addr  = pc_q;
                I_rd    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // IR is not loaded yet, so the branch decodes the incoming word.
                ir_d = I_data;
                pc_d = pc_q + PC_W'(1);
                case (I_data[15:12])
                    4'b0000: state_d = S_LD1;
                    4'b0001: state_d = S_ST1;
                    4'b0011: state_d = S_LI;
                    4'b0101: state_d = S_JZ1;
                    4'b0010, 4'b0100, 4'b0110, 4'b0111,
                    4'b1000, 4'b1001, 4'b1010, 4'b1011: state_d = S_ALU1;
                    4'b1111: state_d = S_HALT;
                    default: state_d = S_FETCH;
                endcase
            end
            S_LD1: begin
                D_addr  = imm_addr;
                D_rd    = 1'b1;
                state_d = S_LD2;
            end
            S_LD2: begin
                RF_s0     = 1'b1;
                RF_W_addr = ra;
                W_wr      = 1'b1;
                state_d   = S_FETCH;
            end
            S_ST1: begin
                RF_Rp_addr = ra;
                Rp_rd      = 1'b1;
                state_d    = S_ST2;
            end
            S_ST2: begin
                D_addr  = imm_addr;
                D_wr    = 1'b1;
                state_d = S_FETCH;
            end
            S_LI: begin
                RF_s1     = 1'b1;
                RF_W_data = (W-8)'(ir_q[7:0]);
                RF_W_addr = ra;
                W_wr      = 1'b1;
                state_d   = S_FETCH;
            end
            S_ALU1: begin
                RF_Rp_addr = rb;
                Rp_rd      = 1'b1;
                RF_Rq_addr = rc;
                Rq_rd      = 1'b1;
                state_d    = S_ALU2;
            end
            S_ALU2: begin
                alu_s     = alu_sel(op);
                RF_W_addr = ra;
                W_wr      = 1'b1;
                state_d   = S_FETCH;
            end
            S_JZ1: begin
                RF_Rp_addr = ra;
                Rp_rd      = 1'b1;
                state_d    = S_JZ2;
            end
            S_JZ2: begin
                // PC already points past the jump, so the offset is relative to that.
                if (RF_Rp_zero) begin
                    pc_d = pc_q + imm_sext;
                end
                state_d = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_risc_16bit_controller.sv
// tb/tb_risc_16bit_controller.sv - self-checking bench for risc_16bit_controller
module tb_risc_16bit_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  I_addr;
    logic        I_rd;
    logic [15:0] I_data = '0;
    logic [7:0]  D_addr;
    logic        D_rd, D_wr;
    logic [7:0]  RF_W_data;
    logic        RF_s1, RF_s0;
    logic [3:0]  RF_W_addr;
    logic        W_wr;
    logic [3:0]  RF_Rp_addr;
    logic        Rp_rd;
    logic [3:0]  RF_Rq_addr;
    logic        Rq_rd;
    logic [2:0]  alu_s;
    logic        RF_Rp_zero = 1'b0;
    logic        halted;

    int checks = 0;
    int errors = 0;
    int mpc    = 0;

    typedef struct packed {
        logic [7:0] i_addr;
        logic       i_rd;
        logic [7:0] d_addr;
        logic       d_rd;
        logic       d_wr;
        logic [7:0] w_data;
        logic [1:0] wsel;
        logic [3:0] w_addr;
        logic       w_wr;
        logic [3:0] rp_addr;
        logic       rp_rd;
        logic [3:0] rq_addr;
        logic       rq_rd;
        logic [2:0] alu_s;
        logic       halted;
    } ovec_t;

    risc_16bit_controller #(.W(16), .PC_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .I_addr(I_addr), .I_rd(I_rd), .I_data(I_data),
        .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr),
        .RF_W_data(RF_W_data), .RF_s1(RF_s1), .RF_s0(RF_s0),
        .RF_W_addr(RF_W_addr), .W_wr(W_wr),
        .RF_Rp_addr(RF_Rp_addr), .Rp_rd(Rp_rd),
        .RF_Rq_addr(RF_Rq_addr), .Rq_rd(Rq_rd),
        .alu_s(alu_s), .RF_Rp_zero(RF_Rp_zero), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic ovec_t observe();
        return {I_addr, I_rd, D_addr, D_rd, D_wr, RF_W_data, RF_s1, RF_s0,
                RF_W_addr, W_wr, RF_Rp_addr, Rp_rd, RF_Rq_addr, Rq_rd, alu_s, halted};
    endfunction

    // ALU opcode table; -1 marks non-ALU opcodes.
    function automatic int alu_code(input int op);
        case (op)
            2: return 0;  4: return 1;  6: return 2;  7: return 3;
            8: return 4;  9: return 5; 10: return 6; 11: return 7;
            default: return -1;
        endcase
    endfunction

    // Instruction length in cycles, FETCH and DECODE included (HALT counts up to entry).
    function automatic int ncycles(input int op);
        if (op == 3) return 3;
        if (op == 0 || op == 1 || op == 5 || alu_code(op) >= 0) return 4;
        return 2;
    endfunction

    // Expected outputs in cycle k of an instruction (k=0 is FETCH).
    function automatic ovec_t model_out(input logic [15:0] ins, input int k, input int pc);
        ovec_t e;
        int op;
        e  = '0;
        op = int'(ins[15:12]);
        if (k == 0) begin
            e.i_addr = 8'(pc);
            e.i_rd   = 1'b1;
        end else if (k == 2) begin
            if (op == 0) begin
                e.d_addr = ins[7:0]; e.d_rd = 1'b1;
            end else if (op == 1 || op == 5) begin
                e.rp_addr = ins[11:8]; e.rp_rd = 1'b1;
            end else if (op == 3) begin
                e.wsel = 2'b10; e.w_data = ins[7:0]; e.w_addr = ins[11:8]; e.w_wr = 1'b1;
            end else if (alu_code(op) >= 0) begin
                e.rp_addr = ins[7:4]; e.rp_rd = 1'b1;
                e.rq_addr = ins[3:0]; e.rq_rd = 1'b1;
            end
        end else if (k == 3) begin
            if (op == 0) begin
                e.wsel = 2'b01; e.w_addr = ins[11:8]; e.w_wr = 1'b1;
            end else if (op == 1) begin
                e.d_addr = ins[7:0]; e.d_wr = 1'b1;
            end else if (alu_code(op) >= 0) begin
                e.alu_s = 3'(alu_code(op)); e.w_addr = ins[11:8]; e.w_wr = 1'b1;
            end
        end
        return e;
    endfunction

    // Runs one instruction (or its first max_k cycles), checking every cycle.
    task automatic run_instr(input logic [15:0] ins, input logic zero, input int max_k = 99);
        int    n, op, off;
        ovec_t exp_v, got;
        op = int'(ins[15:12]);
        n  = ncycles(op);
        if (max_k < n) n = max_k;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            exp_v = model_out(ins, k, mpc);
            got   = observe();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL instr %h cycle %0d got %h exp %h", ins, k, got, exp_v);
            end
            I_data     = (k == 1) ? ins : 16'($urandom);
            RF_Rp_zero = (op == 5 && k == 3) ? zero : 1'($urandom);
            if (k == 1) mpc = (mpc + 1) % 256;
            if (op == 5 && k == 3 && zero) begin
                off = int'(ins[7:0]);
                if (off >= 128) off -= 256;
                mpc = ((mpc + off) % 256 + 256) % 256;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        I_data = 16'($urandom);
        @(negedge clk);
        rst_n = 1'b1;
        mpc   = 0;
    endtask

    task automatic test_reset();
        ovec_t got;
        do_reset();
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", got);
        end
        run_instr(16'hC000, 1'b0);
    endtask

    task automatic test_li();
        do_reset();
        run_instr(16'h3A85, 1'b0);
        run_instr(16'hD000, 1'b0);
        run_instr(16'h3F00, 1'b0);
    endtask

    task automatic test_alu();
        do_reset();
        run_instr(16'h2123, 1'b0);
        run_instr(16'h4123, 1'b0);
        for (int op = 6; op <= 11; op++) begin
            run_instr({4'(op), 12'($urandom)}, 1'b0);
        end
    endtask

    task automatic test_ldst();
        do_reset();
        run_instr(16'h0510, 1'b0);
        run_instr(16'h1620, 1'b0);
    endtask

    task automatic test_jmpz();
        for (int z = 0; z < 2; z++) begin
            do_reset();
            for (int i = 0; i < 4; i++) run_instr(16'hC000, 1'b0);
            run_instr(16'h52FE, 1'(z == 0));
            run_instr(16'hE000, 1'b0);
        end
        do_reset();
        for (int i = 0; i < 255; i++) run_instr(16'hC000, 1'b0);
        run_instr(16'h5205, 1'b1);
        run_instr(16'hC000, 1'b0);
    endtask

    task automatic test_halt();
        ovec_t got, exp_v;
        do_reset();
        run_instr(16'h3102, 1'b0);
        run_instr(16'hF000, 1'b0);
        exp_v = '0;
        exp_v.halted = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL halt_cycle %0d got %h exp %h", i, got, exp_v);
            end
            I_data     = 16'($urandom);
            RF_Rp_zero = 1'($urandom);
        end
        do_reset();
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL halt_reset got %h exp 0", got);
        end
        run_instr(16'hC000, 1'b0);
    endtask

    task automatic test_reset_mid();
        ovec_t got;
        do_reset();
        run_instr(16'hC000, 1'b0);
        run_instr(16'h2456, 1'b0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_in_alu1 got %h exp 0", got);
        end
        rst_n = 1'b1;
        mpc   = 0;
        run_instr(16'hC000, 1'b0);
        run_instr(16'h3777, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] ins;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF) ins[15:12] = 4'h2;
            run_instr(ins, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_li();
        test_alu();
        test_ldst();
        test_jmpz();
        test_halt();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
